// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq_if
// Purpose  : Request/response bundle between the execute stage and the
//            iterative multiply/divide sequencer.
//            master : requester (drives req_*, resp_ready)
//            slave  : sequencer (drives req_ready, resp_*)
// Signals  : req_valid/req_ready handshake, req_op[1:0], req_a, req_b,
//            resp_valid/resp_ready handshake, resp_result, resp_divzero
// Revision : 1.0  initial release
// ============================================================================
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_divzero;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_divzero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_divzero
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Iterative sequencer executing MUL, MULHU, DIVU and REMU on the
//            shared single-cycle ALU, using only its ADD and SUB operations.
//            Shift-add multiply and restoring divide, one bit per cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            bus (slave)     - request/response handshake bundle
//            alu_a, alu_b    - ALU operand drive
//            alu_op          - ALU opcode (4'b0000 ADD, 4'b0001 SUB only)
//            alu_result      - combinational ALU result, same cycle
// Options  : MULDIV_EARLY_OUT_EN - when defined, multiply leaves as soon as
//            the remaining multiplier bits are zero, and divide with
//            dividend < divisor completes at acceptance.
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_muldiv_seq_if.slave   bus,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    input  logic [XLEN-1:0]   alu_result
);

    localparam int              CW      = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   c_last  = CW'(XLEN - 1);
    localparam logic [3:0]      c_op_add = 4'b0000;
    localparam logic [3:0]      c_op_sub = 4'b0001;
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [CW-1:0]   c_xlen  = CW'(XLEN);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Product register {hi, lo} for multiply; for divide hi is the partial
    // remainder and lo the quotient/dividend shift register.
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;        // multiplicand (MUL) or divisor (DIV)
    logic [CW-1:0]   r_cnt;
    logic            r_sel_hi;   // result from hi half: MULHU and REMU
    logic            r_divzero;

    logic            w_b_zero;
    logic            w_carry;
    logic [XLEN:0]   w_rprime;
    logic            w_ge;
    logic            w_last;
    logic            w_div_early;
`ifdef MULDIV_EARLY_OUT_EN
    logic            w_mul_early;
    logic [2*XLEN-1:0] w_mul_shifted;
`endif

    assign w_b_zero = (bus.req_b == '0);
    // ALU sum wrapped around iff it is smaller than one of its addends.
    assign w_carry  = (alu_result < r_hi);
    // Partial remainder shifted left with the next dividend bit.
    assign w_rprime = {r_hi, r_lo[XLEN-1]};
    // Full-width compare: r' can exceed XLEN bits when the divisor has its
    // top bit set, which the ALU difference alone cannot reveal.
    assign w_ge     = (w_rprime >= {1'b0, r_b});
    assign w_last   = (r_cnt == c_last);

`ifdef MULDIV_EARLY_OUT_EN
    // Low XLEN-cnt bits of lo still hold unconsumed multiplier bits.
    assign w_mul_early   = ((r_lo & ({XLEN{1'b1}} >> r_cnt)) == '0);
    assign w_mul_shifted = {r_hi, r_lo} >> (c_xlen - r_cnt);
    assign w_div_early   = (bus.req_a < bus.req_b);
`else
    assign w_div_early   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and ALU drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = c_op_add;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!bus.req_op[1]) begin
                        w_state_nxt = S_MUL;
                    end else if (w_b_zero || w_div_early) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                alu_a  = r_hi;
                alu_b  = r_b;
                alu_op = c_op_add;
`ifdef MULDIV_EARLY_OUT_EN
                if (w_last || w_mul_early) begin
                    w_state_nxt = S_DONE;
                end
`else
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DIV: begin
                alu_a  = w_rprime[XLEN-1:0];
                alu_b  = r_b;
                alu_op = c_op_sub;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_sel_hi  <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_cnt     <= '0;
                        r_sel_hi  <= bus.req_op[0];
                        r_divzero <= 1'b0;
                        if (!bus.req_op[1]) begin
                            r_hi <= '0;
                            r_lo <= bus.req_b;
                            r_b  <= bus.req_a;
                        end else if (w_b_zero) begin
                            // Quotient all-ones, remainder = dividend.
                            r_hi      <= bus.req_a;
                            r_lo      <= '1;
                            r_b       <= bus.req_b;
                            r_divzero <= 1'b1;
                        end else if (w_div_early) begin
                            r_hi <= bus.req_a;
                            r_lo <= '0;
                            r_b  <= bus.req_b;
                        end else begin
                            r_hi <= '0;
                            r_lo <= bus.req_a;
                            r_b  <= bus.req_b;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_mul_early) begin
                        {r_hi, r_lo} <= w_mul_shifted;
                    end else
`endif
                    if (r_lo[0]) begin
                        r_hi <= {w_carry, alu_result[XLEN-1:1]};
                        r_lo <= {alu_result[0], r_lo[XLEN-1:1]};
                    end else begin
                        r_hi <= {1'b0, r_hi[XLEN-1:1]};
                        r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_lo  <= {r_lo[XLEN-2:0], w_ge};
                    // Low XLEN bits of the difference are exact: the true
                    // remainder is always below the divisor.
                    r_hi  <= w_ge ? alu_result : w_rprime[XLEN-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake and response
    // ------------------------------------------------------------------
    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.resp_valid   = (r_state == S_DONE);
    assign bus.resp_result  = (r_state == S_DONE) ? (r_sel_hi ? r_hi : r_lo) : '0;
    assign bus.resp_divzero = (r_state == S_DONE) && r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Self-checking bench for alu_muldiv_seq. Requests push expected
//            responses into a queue; a negedge monitor pops and compares on
//            each new response and checks handshake/ALU-drive invariants.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

    localparam int         XLEN     = 32;
    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_REMU  = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Single-cycle ALU; unsupported opcodes give a corrupted value.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            default: alu_result = ~(alu_a + alu_b);
        endcase
    end

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            dz;
        int              acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic rr_random = 1'b0;
    logic rr_force  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bus.resp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic and the divide-by-zero rules.
    function automatic exp_t model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t       e;
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        e.op = op; e.a = a; e.b = b; e.acc = 0;
        e.dz = op[1] && (b == 0);
        case (op)
            OP_MUL:   e.res = p[31:0];
            OP_MULHU: e.res = p[63:32];
            OP_DIVU:  e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  e.res = (b == 0) ? a : a % b;
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        e = model(op, a, b);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            n++;
            if (n > 300) begin
                chk("req_ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        push_exp(op, a, b);
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (q.size() != 0 || bus.resp_valid || !bus.req_ready) begin
            n++;
            if (n > 300) begin
                chk("idle_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic            armed = 1'b1;
    logic [XLEN-1:0] last_res = '0;
    logic            last_dz  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic busy;
        int   lat;
        if (rst) begin
            armed = 1'b1;
        end else begin
            if (bus.resp_valid && armed) begin
                armed = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("result op%0d a=%0h b=%0h", e.op, e.a, e.b), bus.resp_result, e.res);
                    chk("divzero", bus.resp_divzero, e.dz);
                    lat = cyc - e.acc + 1;
`ifdef MULDIV_EARLY_OUT_EN
                    chk("latency_bound", (lat >= 1 && lat <= XLEN + 1), 1);
`else
                    chk("latency", lat, e.dz ? 1 : XLEN + 1);
`endif
                    last_res = e.res;
                    last_dz  = e.dz;
                end
            end else if (bus.resp_valid) begin
                chk("resp_stable", bus.resp_result, last_res);
                chk("divzero_stable", bus.resp_divzero, last_dz);
            end
            if (!bus.resp_valid) armed = 1'b1;

            busy = (q.size() > 0);
            chk("req_ready", bus.req_ready, !(busy || bus.resp_valid));
            if (busy) begin
                chk("alu_op_busy", alu_op, q[0].op[1] ? 4'b0001 : 4'b0000);
                chk("alu_b_busy", alu_b, q[0].op[1] ? q[0].b : q[0].a);
            end else begin
                chk("alu_idle", {alu_op, alu_a, alu_b}, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            seen;
        int              n;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_result", bus.resp_result, 0);
        chk("rst_divzero", bus.resp_divzero, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        rst = 1'b0;

        // Directed operations
        do_req(OP_MUL,   32'd7,          32'd6);
        do_req(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_req(OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_req(OP_DIVU,  32'd100,        32'd7);
        do_req(OP_REMU,  32'd100,        32'd7);
        do_req(OP_DIVU,  32'hFFFF_FFFF,  32'h8000_0001);
        do_req(OP_DIVU,  32'd5,          32'd0);
        do_req(OP_REMU,  32'd5,          32'd0);
        do_req(OP_MUL,   32'd0,          32'h1234_5678);
        do_req(OP_MULHU, 32'h9ABC_DEF0,  32'd0);
        do_req(OP_DIVU,  32'hCAFE_BABE,  32'd1);
        do_req(OP_REMU,  32'hCAFE_BABE,  32'd1);
        do_req(OP_DIVU,  32'd5,          32'd9);
        do_req(OP_REMU,  32'd5,          32'd9);
        wait_idle();

        // Back-pressure hold, then back-to-back request
        rr_force = 1'b0;
        repeat (2) @(negedge clk);
        do_req(OP_MULHU, 32'h8765_4321, 32'h0FED_CBA9);
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("hold_resp_seen", bus.resp_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", bus.resp_valid, 1);
        end
        @(posedge clk);
        #1;
        rr_force      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_a     = 32'd11;
        bus.req_b     = 32'd13;
        @(posedge clk);
        #1;
        chk("exit_valid_low", bus.resp_valid, 0);
        chk("exit_ready_high", bus.req_ready, 1);
        @(posedge clk);
        #1;
        chk("b2b_accepted", bus.req_ready, 0);
        push_exp(OP_MUL, 32'd11, 32'd13);
        bus.req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a divide
        do_req(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_resp_result", bus.resp_result, 0);
        chk("abort_alu", {alu_op, alu_a, alu_b}, 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("abort_no_resp", seen, 0);
        do_req(OP_MUL, 32'd3, 32'd3);
        wait_idle();

        // Randomized operations with random back-pressure
        rr_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 15));
                2:       b = (i % 5 == 0) ? 32'd0 : a >> $urandom_range(0, 31);
                default: b = a + 32'($urandom_range(0, 3));
            endcase
            do_req(op, a, b);
        end
        wait_idle();
        rr_random = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
